// File: rtl/tl_pkg.sv
// Shared types for the write-data-buffer allocator: command encoding and CQ entry layout.
package tl_pkg;
  typedef enum logic [1:0] {
    TL_NOP   = 2'd0,
    TL_WRITE = 2'd1,
    TL_READ  = 2'd2,
    TL_RSVD  = 2'd3
  } tl_cmd_e;

  localparam int TL_ADDR_W = 64;
  localparam int TL_PTR_W  = 3;

  // Entry layout for the default configuration; the block packs the same field order.
  typedef struct packed {
    tl_cmd_e               cmd;
    logic [TL_ADDR_W-1:0]  addr;
    logic [TL_PTR_W-1:0]   ptr;
  } tl_cq_entry_t;
endpackage

// File: rtl/tl_wdf_alloc_if.sv
// Command, write-buffer, command-queue and release signals of tl_wdf_alloc.
interface tl_wdf_alloc_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int PTR_W  = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wdf_wr;
  logic [PTR_W-1:0]  wdf_ptr;
  logic [DATA_W-1:0] wdf_data;
  logic              cq_valid;
  logic              cq_ready;
  logic [1:0]        cq_cmd;
  logic [ADDR_W-1:0] cq_addr;
  logic [PTR_W-1:0]  cq_ptr;
  logic              rel_valid;
  logic [PTR_W-1:0]  rel_ptr;
  logic [PTR_W:0]    free_cnt;
  logic              err_cmd;
  logic              err_rel;

  modport master (
    output cmd_valid, cmd, addr, data, cq_ready, rel_valid, rel_ptr,
    input  cmd_ready, wdf_wr, wdf_ptr, wdf_data, cq_valid, cq_cmd, cq_addr, cq_ptr,
           free_cnt, err_cmd, err_rel
  );
  modport slave (
    input  cmd_valid, cmd, addr, data, cq_ready, rel_valid, rel_ptr,
    output cmd_ready, wdf_wr, wdf_ptr, wdf_data, cq_valid, cq_cmd, cq_addr, cq_ptr,
           free_cnt, err_cmd, err_rel
  );
endinterface

// File: rtl/tl_cq_fifo.sv
// Generic synchronous FIFO; head is presented combinationally and reads as zero when empty.
module tl_cq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle makes room, so push is legal even when full.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/tl_wdf_alloc.sv
// Write-data-buffer slot allocator: accepts commands, hands out the lowest free slot
// for writes, queues commands for the scheduler and recycles released slots.
module tl_wdf_alloc
  import tl_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int WDF_DEPTH = 8,
  parameter int CQ_DEPTH  = 4,
  parameter int PTR_W     = $clog2(WDF_DEPTH)
) (
  input logic           clk,
  input logic           rst,
  tl_wdf_alloc_if.slave bus
);
  localparam int ENT_W = 2 + ADDR_W + PTR_W;

  logic [WDF_DEPTH-1:0] free_mask, mask_nxt;
  logic [PTR_W:0]       free_cnt;
  logic [PTR_W-1:0]     alloc_ptr;
  logic [ENT_W-1:0]     cq_din, cq_dout;
  logic                 run, cq_full, cq_empty, hs, alloc, push, rel_ok;
  tl_cmd_e              cmd;

  assign cmd = tl_cmd_e'(bus.cmd);

  // run holds ready low until the first edge after reset is released.
  assign bus.cmd_ready = !rst && run && !cq_full && (free_cnt != '0);
  assign hs     = bus.cmd_valid && bus.cmd_ready;
  assign alloc  = hs && (cmd == TL_WRITE);
  assign push   = hs && (cmd == TL_WRITE || cmd == TL_READ);
  // Only a slot busy in the registered mask can be released, so a slot being
  // allocated this same cycle counts as already free.
  assign rel_ok = bus.rel_valid && !free_mask[bus.rel_ptr];

  always_comb begin
    alloc_ptr = '0;
    for (int i = WDF_DEPTH-1; i >= 0; i--)
      if (free_mask[i]) alloc_ptr = PTR_W'(i);
  end

  always_comb begin
    mask_nxt = free_mask;
    if (alloc)  mask_nxt[alloc_ptr]   = 1'b0;
    if (rel_ok) mask_nxt[bus.rel_ptr] = 1'b1;
  end

  assign cq_din = {bus.cmd, bus.addr, (cmd == TL_WRITE) ? alloc_ptr : PTR_W'(0)};

  tl_cq_fifo #(.W(ENT_W), .DEPTH(CQ_DEPTH)) u_cq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cq_din),
    .pop   (bus.cq_ready),
    .dout  (cq_dout),
    .full  (cq_full),
    .empty (cq_empty)
  );

  assign bus.cq_valid = !cq_empty;
  assign {bus.cq_cmd, bus.cq_addr, bus.cq_ptr} = cq_dout;
  assign bus.free_cnt = free_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      run          <= 1'b0;
      free_mask    <= '1;
      free_cnt     <= (PTR_W+1)'(WDF_DEPTH);
      bus.wdf_wr   <= 1'b0;
      bus.wdf_ptr  <= '0;
      bus.wdf_data <= '0;
      bus.err_cmd  <= 1'b0;
      bus.err_rel  <= 1'b0;
    end else begin
      run         <= 1'b1;
      free_mask   <= mask_nxt;
      free_cnt    <= (PTR_W+1)'($countones(mask_nxt));
      bus.wdf_wr  <= alloc;
      if (alloc) begin
        bus.wdf_ptr  <= alloc_ptr;
        bus.wdf_data <= bus.data;
      end
      bus.err_cmd <= hs && (cmd == TL_RSVD);
      bus.err_rel <= bus.rel_valid && !rel_ok;
    end
  end
endmodule
